// File: rtl/debug_abstract_cmd_encoder.sv
// Abstract-command to RV32I/Zicsr instruction-stream encoder for the debug fetch path.
// Issues one instruction at a time, waits for retire/trap/timeout, then reports status.
module debug_abstract_cmd_encoder #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned TIMEOUT_W      = 9
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_type,
   input  logic [11:0] cmd_regno,
   input  logic [31:0] cmd_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   input  logic        inst_retired,
   input  logic        inst_exception,
   output logic        resp_valid,
   output logic [1:0]  resp_err,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [1:0]  CMD_GPR_RD = 2'd0;
   localparam logic [1:0]  CMD_GPR_WR = 2'd1;
   localparam logic [1:0]  CMD_CSR_RD = 2'd2;
   localparam logic [1:0]  CMD_CSR_WR = 2'd3;

   localparam logic [1:0]  ERR_OK      = 2'd0;
   localparam logic [1:0]  ERR_UNSUPP  = 2'd1;
   localparam logic [1:0]  ERR_EXCEPT  = 2'd2;
   localparam logic [1:0]  ERR_TIMEOUT = 2'd3;

   localparam logic [11:0] CSR_DSCRATCH = 12'h7B2;
   localparam logic [4:0]  X0 = 5'd0;
   localparam logic [4:0]  X1 = 5'd1;

   localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   function automatic logic [31:0] f_csr(input logic [11:0] csr, input logic [4:0] rs1,
                                         input logic [2:0] fn3, input logic [4:0] rd);
      return {csr, rs1, fn3, rd, 7'b1110011};
   endfunction

   function automatic logic [31:0] f_lui(input logic [4:0] rd, input logic [19:0] imm);
      return {imm, rd, 7'b0110111};
   endfunction

   function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction

   state_t                r_state;
   state_t                w_next_state;
   logic [1:0]            r_type;
   logic [11:0]           r_regno;
   logic [31:0]           r_data;
   logic [2:0]            r_step;
   logic [2:0]            w_next_step;
   logic [1:0]            r_err;
   logic [1:0]            w_next_err;
   logic [TIMEOUT_W-1:0]  r_timer;

   logic                  w_accept;
   logic                  w_illegal;
   logic                  w_x0_write;
   logic [2:0]            w_last_step;
   logic [4:0]            w_gpr;
   logic [19:0]           w_hi;
   logic [11:0]           w_lo;
   logic [31:0]           w_inst;

   assign w_accept   = cmd_valid && (r_state == S_IDLE);
   assign w_illegal  = (!cmd_type[1] && (cmd_regno > 12'd31)) ||
                       ((cmd_type == CMD_CSR_WR) && (cmd_regno[11:10] == 2'b11));
   assign w_x0_write = (cmd_type == CMD_GPR_WR) && (cmd_regno == 12'd0);

   assign w_gpr = r_regno[4:0];
   assign w_lo  = r_data[11:0];
   // Rounding the upper part compensates for ADDI sign-extending the low 12 bits.
   assign w_hi  = r_data[31:12] + {19'd0, r_data[11]};

   always_comb begin
      w_last_step = 3'd0;
      case (r_type)
         CMD_GPR_RD: w_last_step = 3'd0;
         CMD_GPR_WR: w_last_step = 3'd1;
         CMD_CSR_RD: w_last_step = 3'd2;
         default:    w_last_step = 3'd4;
      endcase
   end

   always_comb begin
      w_inst = '0;
      case (r_type)
         CMD_GPR_RD: w_inst = f_csr(CSR_DSCRATCH, w_gpr, 3'b001, X0);
         CMD_GPR_WR: begin
            if (r_step == 3'd0) w_inst = f_lui(w_gpr, w_hi);
            else                w_inst = f_addi(w_gpr, w_gpr, w_lo);
         end
         CMD_CSR_RD: begin
            case (r_step)
               3'd0:    w_inst = f_csr(CSR_DSCRATCH, X1, 3'b001, X0);
               3'd1:    w_inst = f_csr(r_regno, X0, 3'b010, X1);
               default: w_inst = f_csr(CSR_DSCRATCH, X1, 3'b001, X1);
            endcase
         end
         default: begin
            case (r_step)
               3'd0:    w_inst = f_csr(CSR_DSCRATCH, X1, 3'b001, X0);
               3'd1:    w_inst = f_lui(X1, w_hi);
               3'd2:    w_inst = f_addi(X1, X1, w_lo);
               3'd3:    w_inst = f_csr(r_regno, X1, 3'b001, X0);
               default: w_inst = f_csr(CSR_DSCRATCH, X0, 3'b001, X1);
            endcase
         end
      endcase
   end

   always_comb begin
      w_next_state = r_state;
      w_next_step  = r_step;
      w_next_err   = r_err;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_next_step = '0;
               if (w_illegal) begin
                  w_next_state = S_RESP;
                  w_next_err   = ERR_UNSUPP;
               end else if (w_x0_write) begin
                  w_next_state = S_RESP;
                  w_next_err   = ERR_OK;
               end else begin
                  w_next_state = S_ISSUE;
                  w_next_err   = ERR_OK;
               end
            end
         end
         S_ISSUE: begin
            if (inst_ready) w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (inst_exception) begin
               w_next_state = S_RESP;
               w_next_err   = ERR_EXCEPT;
            end else if (inst_retired) begin
               if (r_step == w_last_step) begin
                  w_next_state = S_RESP;
                  w_next_err   = ERR_OK;
               end else begin
                  w_next_state = S_ISSUE;
                  w_next_step  = r_step + 3'd1;
               end
            end else if (r_timer == TIMER_LAST) begin
               w_next_state = S_RESP;
               w_next_err   = ERR_TIMEOUT;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_step  <= '0;
         r_err   <= ERR_OK;
         r_timer <= '0;
         r_type  <= '0;
         r_regno <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_next_state;
         r_step  <= w_next_step;
         r_err   <= w_next_err;
         if (r_state == S_ISSUE)     r_timer <= '0;
         else if (r_state == S_WAIT) r_timer <= r_timer + 1'b1;
         if (w_accept) begin
            r_type  <= cmd_type;
            r_regno <= cmd_regno;
            r_data  <= cmd_data;
         end
      end
   end

   assign cmd_ready  = (r_state == S_IDLE);
   assign inst_valid = (r_state == S_ISSUE);
   assign inst       = (r_state == S_ISSUE) ? w_inst : '0;
   assign resp_valid = (r_state == S_RESP);
   assign resp_err   = (r_state == S_RESP) ? r_err : ERR_OK;
   assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_debug_abstract_cmd_encoder.sv
// Directed bench for debug_abstract_cmd_encoder: expected instruction words and
// response codes are queued when a command is driven and checked as the DUT emits them.
module tb_debug_abstract_cmd_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_type = '0;
   logic [11:0] cmd_regno = '0;
   logic [31:0] cmd_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic        inst_retired = 1'b0;
   logic        inst_exception = 1'b0;
   logic        resp_valid;
   logic [1:0]  resp_err;
   logic        busy;

   int checks = 0;
   int failures = 0;

   logic [31:0] q_inst[$];
   logic [1:0]  q_resp[$];

   debug_abstract_cmd_encoder #(
      .TIMEOUT_CYCLES(4),
      .TIMEOUT_W(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_type(cmd_type),
      .cmd_regno(cmd_regno),
      .cmd_data(cmd_data),
      .inst_valid(inst_valid),
      .inst_ready(inst_ready),
      .inst(inst),
      .inst_retired(inst_retired),
      .inst_exception(inst_exception),
      .resp_valid(resp_valid),
      .resp_err(resp_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: compare every accepted instruction and every response.
   always @(negedge clk) begin
      logic [31:0] exp_inst;
      logic [1:0]  exp_resp;
      if (rst_n) begin
         if (inst_valid && inst_ready) begin
            if (q_inst.size() != 0) exp_inst = q_inst.pop_front();
            else                    exp_inst = 'x;
            chk("inst_word", inst, exp_inst);
         end
         if (resp_valid) begin
            if (q_resp.size() != 0) exp_resp = q_resp.pop_front();
            else                    exp_resp = 'x;
            chk("resp_err", {30'd0, resp_err}, {30'd0, exp_resp});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] t, input logic [11:0] r, input logic [31:0] d);
      step_clk();
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_type  = t;
      cmd_regno = r;
      cmd_data  = d;
      step_clk();
      cmd_valid = 1'b0;
      cmd_data  = '0;
   endtask

   // Entry point is one step after the edge that should have put the DUT into ISSUE.
   task automatic issue_one(input int stall, input bit stray, input int wait_c,
                            input bit ret, input bit exc);
      logic [31:0] held;
      chk("inst_valid_issue", inst_valid, 1);
      chk("busy_issue", busy, 1);
      held = inst;
      for (int i = 0; i < stall; i++) begin
         inst_retired = stray && (i == 0);
         step_clk();
         inst_retired = 1'b0;
         chk("inst_valid_stall", inst_valid, 1);
         chk("inst_stable_stall", inst, held);
      end
      inst_ready = 1'b1;
      step_clk();
      inst_ready = 1'b0;
      chk("inst_valid_wait", inst_valid, 0);
      for (int i = 0; i < wait_c; i++) step_clk();
      inst_retired   = ret;
      inst_exception = exc;
      step_clk();
      inst_retired   = 1'b0;
      inst_exception = 1'b0;
   endtask

   task automatic finish_resp();
      chk("resp_valid_pulse", resp_valid, 1);
      chk("busy_in_resp", busy, 1);
      chk("cmd_ready_in_resp", cmd_ready, 0);
      step_clk();
      chk("resp_valid_single", resp_valid, 0);
      chk("busy_after_resp", busy, 0);
      chk("inst_valid_after_resp", inst_valid, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_inst", inst, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_err", {30'd0, resp_err}, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;

      // GPR read x10
      q_inst.push_back(32'h7B251073);
      q_resp.push_back(2'd0);
      send(2'd0, 12'd10, 32'h0);
      issue_one(0, 0, 1, 1, 0);
      finish_resp();

      // GPR write x5 = 0x12345FFF (negative low part)
      q_inst.push_back(32'h123462B7);
      q_inst.push_back(32'hFFF28293);
      q_resp.push_back(2'd0);
      send(2'd1, 12'd5, 32'h12345FFF);
      issue_one(0, 0, 0, 1, 0);
      issue_one(1, 0, 2, 1, 0);
      finish_resp();

      // CSR read MEPC with stalls and a stray retire during ISSUE
      q_inst.push_back(32'h7B209073);
      q_inst.push_back(32'h341020F3);
      q_inst.push_back(32'h7B2090F3);
      q_resp.push_back(2'd0);
      send(2'd2, 12'h341, 32'h0);
      issue_one(3, 1, 1, 1, 0);
      issue_one(0, 0, 0, 1, 0);
      issue_one(2, 0, 1, 1, 0);
      finish_resp();

      // Illegal GPR index
      q_resp.push_back(2'd1);
      send(2'd0, 12'd40, 32'h0);
      chk("illegal_gpr_no_inst", inst_valid, 0);
      finish_resp();

      // CSR write to read-only space
      q_resp.push_back(2'd1);
      send(2'd3, 12'hC00, 32'h1);
      chk("ro_csr_no_inst", inst_valid, 0);
      finish_resp();

      // GPR write x0 completes with no instructions
      q_resp.push_back(2'd0);
      send(2'd1, 12'd0, 32'hDEADBEEF);
      chk("x0_no_inst", inst_valid, 0);
      finish_resp();

      // Full CSR write 0x300 = 8
      q_inst.push_back(32'h7B209073);
      q_inst.push_back(32'h000000B7);
      q_inst.push_back(32'h00808093);
      q_inst.push_back(32'h30009073);
      q_inst.push_back(32'h7B2010F3);
      q_resp.push_back(2'd0);
      send(2'd3, 12'h300, 32'h00000008);
      for (int s = 0; s < 5; s++) issue_one(0, 0, s % 3, 1, 0);
      finish_resp();

      // CSR write 0x305 trapping on step 2
      q_inst.push_back(32'h7B209073);
      q_inst.push_back(32'h000020B7);
      q_resp.push_back(2'd2);
      send(2'd3, 12'h305, 32'h00001888);
      issue_one(0, 0, 0, 1, 0);
      issue_one(0, 0, 1, 0, 1);
      finish_resp();
      chk("exc_no_more_inst", 32'(q_inst.size()), 0);

      // Retire and exception together: exception wins
      q_inst.push_back(32'h7B219073);
      q_resp.push_back(2'd2);
      send(2'd0, 12'd3, 32'h0);
      issue_one(0, 0, 0, 1, 1);
      finish_resp();

      // Timeout: response exactly four edges after the handshake
      q_inst.push_back(32'h7B219073);
      q_resp.push_back(2'd3);
      send(2'd0, 12'd3, 32'h0);
      issue_one(0, 0, 2, 0, 0);
      chk("no_resp_before_timeout", resp_valid, 0);
      step_clk();
      finish_resp();

      // Reset during ISSUE aborts silently
      send(2'd2, 12'h341, 32'h0);
      chk("mid_inst_valid_before_rst", inst_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      chk("mid_rst_inst_valid", inst_valid, 0);
      chk("mid_rst_inst", inst, 0);
      chk("mid_rst_resp_valid", resp_valid, 0);
      chk("mid_rst_busy", busy, 0);
      step_clk();
      rst_n = 1'b1;
      step_clk();
      chk("post_rst_resp_valid", resp_valid, 0);

      // Normal command after reset release
      q_inst.push_back(32'h7B251073);
      q_resp.push_back(2'd0);
      send(2'd0, 12'd10, 32'h0);
      issue_one(0, 0, 0, 1, 0);
      finish_resp();

      repeat (3) step_clk();
      chk("inst_queue_drained", 32'(q_inst.size()), 0);
      chk("resp_queue_drained", 32'(q_resp.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
